axi4_mem_responder: RTL and testbench

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

---
 rtl/axi4_mem_pkg.sv | 17 +
 rtl/axi4_mem_bram.sv | 34 +++
 rtl/axi4_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_axi4_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_mem_pkg.sv
// Shared definitions for the AXI4 memory responder: FSM states and sizing constants.
package axi4_mem_pkg;

    localparam int BEAT_W     = 8;
    localparam int WORD_BYTES = 4;

    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RFETCH,
        ST_RDATA
    } state_e;

endpackage

// File: rtl/axi4_mem_bram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module axi4_mem_bram
    import axi4_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [WORD_BYTES-1:0]   be,
    input  logic [AW-1:0]           addr,
    input  logic [8*WORD_BYTES-1:0] wdata,
    output logic [8*WORD_BYTES-1:0] rdata
);

    // One narrow array per byte lane keeps each lane a clean single-writer RAM.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                mem[addr] <= wdata[gi*8 +: 8];
            end
            if (en) begin
                rd_q <= mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 INCR-burst memory slave, one transaction at a time, 32-bit words.
// Define AXI4_MEM_RESPONDER_WLAST_CHK_EN to add the sticky err_wlast output.
module axi4_mem_responder
    import axi4_mem_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_DEPTH_WORDS  = 4096
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast
`ifdef AXI4_MEM_RESPONDER_WLAST_CHK_EN
    ,
    output logic                            err_wlast
`endif
);

    localparam int IDX_W = $clog2(C_MEM_DEPTH_WORDS);

    typedef logic [IDX_W-1:0] idx_t;

    state_e state_q, state_d;
    idx_t   idx_q, idx_d;
    beat_t  len_q, len_d;
    beat_t  beat_q, beat_d;
    logic   rvalid_q, rvalid_d;
    logic   rlast_q, rlast_d;

    logic                    last_beat;
    logic                    w_hs;
    logic                    mem_we;
    logic                    mem_en;
    logic [8*WORD_BYTES-1:0] mem_rdata;

    assign last_beat = (beat_q == len_q);
    assign w_hs      = (state_q == ST_WDATA) && s_axi_wvalid;
    assign mem_we    = w_hs;
    assign mem_en    = (state_q == ST_RFETCH);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        beat_d   = beat_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        case (state_q)
            ST_IDLE: begin
                // Write wins when both address channels are valid together.
                if (s_axi_awvalid) begin
                    idx_d   = s_axi_awaddr[IDX_W+1:2];
                    len_d   = s_axi_awlen;
                    beat_d  = '0;
                    state_d = ST_WDATA;
                end else if (s_axi_arvalid) begin
                    idx_d   = s_axi_araddr[IDX_W+1:2];
                    len_d   = s_axi_arlen;
                    beat_d  = '0;
                    state_d = ST_RFETCH;
                end
            end
            ST_WDATA: begin
                if (s_axi_wvalid) begin
                    idx_d  = idx_t'(idx_q + 1'b1);
                    beat_d = beat_t'(beat_q + 1'b1);
                    if (last_beat) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (s_axi_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RFETCH: begin
                rvalid_d = 1'b1;
                rlast_d  = last_beat;
                state_d  = ST_RDATA;
            end
            ST_RDATA: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_t'(idx_q + 1'b1);
                        beat_d  = beat_t'(beat_q + 1'b1);
                        state_d = ST_RFETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    axi4_mem_bram #(
        .DEPTH (C_MEM_DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_bram (
        .clk   (ap_clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (s_axi_wstrb),
        .addr  (idx_q),
        .wdata (s_axi_wdata),
        .rdata (mem_rdata)
    );

    // Readies are masked by areset so they read low while reset is held.
    assign s_axi_awready = (state_q == ST_IDLE) && !areset;
    assign s_axi_arready = (state_q == ST_IDLE) && !s_axi_awvalid && !areset;
    assign s_axi_wready  = (state_q == ST_WDATA);
    assign s_axi_bvalid  = (state_q == ST_WRESP);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rvalid_q ? mem_rdata : '0;

`ifdef AXI4_MEM_RESPONDER_WLAST_CHK_EN
    logic err_wlast_q, err_wlast_d;

    always_comb begin
        err_wlast_d = err_wlast_q | (w_hs && (s_axi_wlast != last_beat));
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            err_wlast_q <= 1'b0;
        end else begin
            err_wlast_q <= err_wlast_d;
        end
    end

    assign err_wlast = err_wlast_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s_axi_awaddr[1:0],
                                s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[1:0]};
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s_axi_awaddr[1:0],
                                s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[1:0],
                                s_axi_wlast};
`endif

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder; expected read data comes from a bench-side word model.
module tb_axi4_mem_responder;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [63:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic        rlast;
`ifdef AXI4_MEM_RESPONDER_WLAST_CHK_EN
    logic        err_wlast;
`endif

    always #5 ap_clk = ~ap_clk;

    axi4_mem_responder dut (
        .ap_clk        (ap_clk),
        .areset        (areset),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rlast   (rlast)
`ifdef AXI4_MEM_RESPONDER_WLAST_CHK_EN
        ,
        .err_wlast     (err_wlast)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [4096];
    logic [31:0] wdat  [256];
    logic [3:0]  wstb  [256];
    logic [31:0] got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic int idx_of(input logic [63:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0: return awready;
            1: return arready;
            2: return wready;
            3: return rvalid;
            default: return bvalid;
        endcase
    endfunction

    // Caller sits at a negedge; returns at the negedge where the signal is high (or budget expired).
    task automatic wait_for(input string tag, input int sel);
        int n = 0;
        while (!pick(sel) && n < 64) begin
            @(negedge ap_clk);
            n++;
        end
        chk(tag, 32'(n < 64), 32'd1);
    endtask

    task automatic axi_write(input logic [63:0] addr, input int len, input bit bad_wlast,
                             input bit with_ar);
        @(posedge ap_clk); #1;
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = 8'(len);
        if (with_ar) arvalid = 1'b1;
        @(negedge ap_clk);
        wait_for("awready", 0);
        if (arvalid) chk("ar_blocked_by_aw", 32'(arready), 32'd0);
        @(posedge ap_clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1;
            wdata  = wdat[b];
            wstrb  = wstb[b];
            wlast  = bad_wlast ? (b == 0) : (b == len);
            @(negedge ap_clk);
            wait_for("wready", 2);
            for (int i = 0; i < 4; i++) begin
                if (wstb[b][i]) model[(idx_of(addr) + b) % 4096][i*8 +: 8] = wdat[b][i*8 +: 8];
            end
            @(posedge ap_clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge ap_clk);
        chk("bvalid_after_last_w", 32'(bvalid), 32'd1);
        chk("wready_off_in_wresp", 32'(wready), 32'd0);
        if (arvalid) chk("ar_pending_in_wresp", 32'(arready), 32'd0);
        bready = 1'b1;
        @(posedge ap_clk); #1;
        bready = 1'b0;
        @(negedge ap_clk);
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic pop_exp(output logic [31:0] e);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // pre: arvalid/araddr/arlen already driven by the caller.
    task automatic axi_read(input logic [63:0] addr, input int len, input bit stall, input bit pre,
                            output logic [31:0] last_data);
        logic [31:0] e;
        last_data = '0;
        for (int b = 0; b <= len; b++) exp_q.push_back(model[(idx_of(addr) + b) % 4096]);
        if (!pre) begin
            @(posedge ap_clk); #1;
            arvalid = 1'b1;
            araddr  = addr;
            arlen   = 8'(len);
            @(negedge ap_clk);
        end
        rready = 1'b1;
        wait_for("arready", 1);
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        @(negedge ap_clk);
        chk("rvalid_low_in_fetch", 32'(rvalid), 32'd0);
        for (int b = 0; b <= len; b++) begin
            @(posedge ap_clk); #1;
            rready = !(stall && b == 1);
            @(negedge ap_clk);
            chk("rvalid_two_after", 32'(rvalid), 32'd1);
            pop_exp(e);
            chk("rdata", rdata, e);
            chk("rlast", 32'(rlast), 32'(b == len));
            last_data = rdata;
            if (!rready) begin
                @(posedge ap_clk); #1;
                rready = 1'b1;
                @(negedge ap_clk);
                chk("rvalid_hold", 32'(rvalid), 32'd1);
                chk("rdata_hold", rdata, e);
                chk("rlast_hold", 32'(rlast), 32'(b == len));
            end
            @(posedge ap_clk); #1;
            @(negedge ap_clk);
            chk("rvalid_gap", 32'(rvalid), 32'd0);
        end
        chk("idle_after_read", 32'(awready), 32'd1);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] e;

        repeat (3) @(negedge ap_clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_awready", 32'(awready), 32'd1);
        chk("post_rst_arready", 32'(arready), 32'd1);

        // single beat
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        axi_write(64'h100, 0, 1'b0, 1'b0);
        axi_read(64'h100, 0, 1'b0, 1'b0, got);
        chk("single_data", got, 32'hDEADBEEF);

        // 4-beat burst, read with a stall on beat 1
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i);
            wstb[i] = 4'hF;
        end
        axi_write(64'h0, 3, 1'b0, 1'b0);
        axi_read(64'h0, 3, 1'b1, 1'b0, got);
        chk("burst_last_data", got, 32'd3);

        // byte strobes
        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        axi_write(64'h200, 0, 1'b0, 1'b0);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'h2;
        axi_write(64'h200, 0, 1'b0, 1'b0);
        axi_read(64'h200, 0, 1'b0, 1'b0, got);
        chk("strobe_merge", got, 32'h1122CC44);

        // wrap from the top word back to word 0
        wdat[0] = 32'hA5A50001; wstb[0] = 4'hF;
        wdat[1] = 32'h5A5A0002; wstb[1] = 4'hF;
        axi_write(64'h3FFC, 1, 1'b0, 1'b0);
        axi_read(64'h3FFC, 1, 1'b0, 1'b0, got);
        chk("wrap_read_beat1", got, 32'h5A5A0002);
        axi_read(64'h0, 0, 1'b0, 1'b0, got);
        chk("wrap_word0", got, 32'h5A5A0002);
        axi_read(64'h3FFC, 0, 1'b0, 1'b0, got);
        chk("wrap_word4095", got, 32'hA5A50001);
        axi_read(64'h1_0000, 0, 1'b0, 1'b0, got);
        chk("alias_upper_bits", got, 32'h5A5A0002);

        // simultaneous AW and AR: write first, then the pending read sees new data
        araddr = 64'h300; arlen = 8'd0;
        wdat[0] = 32'hC0FFEE11; wstb[0] = 4'hF;
        axi_write(64'h300, 0, 1'b0, 1'b1);
        chk("ar_ready_after_b", 32'(arready), 32'd1);
        axi_read(64'h300, 0, 1'b0, 1'b1, got);
        chk("sim_read_new_data", got, 32'hC0FFEE11);

        // reset in the middle of a 4-beat read
        for (int b = 0; b < 4; b++) exp_q.push_back(model[b]);
        @(posedge ap_clk); #1;
        arvalid = 1'b1; araddr = 64'h0; arlen = 8'd3; rready = 1'b1;
        @(negedge ap_clk);
        wait_for("arready_rst", 1);
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        @(negedge ap_clk);
        wait_for("rvalid_b0", 3);
        pop_exp(e);
        chk("rst_rd_b0", rdata, e);
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        wait_for("rvalid_b1", 3);
        pop_exp(e);
        chk("rst_rd_b1", rdata, e);
        areset = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rlast",  32'(rlast),  32'd0);
        chk("midrst_rdata",  rdata,       32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        exp_q.delete();
        rready = 1'b0;
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        chk("rerst_awready", 32'(awready), 32'd1);
        chk("rerst_arready", 32'(arready), 32'd1);
        axi_read(64'h200, 0, 1'b0, 1'b0, got);
        chk("mem_kept_over_rst", got, 32'h1122CC44);

`ifdef AXI4_MEM_RESPONDER_WLAST_CHK_EN
        chk("err_wlast_clear", 32'(err_wlast), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wdat[i] = 32'h7000 + 32'(i);
            wstb[i] = 4'hF;
        end
        axi_write(64'h400, 2, 1'b1, 1'b0);
        chk("err_wlast_set", 32'(err_wlast), 32'd1);
        axi_read(64'h400, 2, 1'b0, 1'b0, got);
        chk("err_wlast_sticky", 32'(err_wlast), 32'd1);
        areset = 1'b1;
        #1;
        chk("err_wlast_rst", 32'(err_wlast), 32'd0);
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
